rename_serialize_ctrl: RTL and testbench

RENAME_SERIALIZE_CTRL -- requirements
Module: rename_serialize_ctrl

---
 rtl/rename_serialize_ctrl_pkg.sv | 22 ++
 rtl/rename_serialize_ctrl_if.sv | 30 +++
 rtl/rename_serialize_ctrl_lane_sel.sv | 34 +++
 rtl/rename_serialize_ctrl.sv | 124 ++++++++++++
 tb/tb_rename_serialize_ctrl.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/rename_serialize_ctrl_pkg.sv
// Shared types for the rename-stage serializer: phase encoding, counter width
// default and the lane-mask type.
package RenameSerializerTypes;

  typedef enum logic [1:0] {
    SP_NORMAL   = 2'd0,
    SP_DRAIN    = 2'd1,
    SP_WAIT_OWN = 2'd2
  } SerializePhase;

  localparam int SERIALIZE_CNT_WIDTH = 16;
  localparam int SERIALIZE_MAX_LANES = 8;

  // Lane masks are carried at the widest legal group size; a block with fewer
  // lanes uses the low WIDTH bits.
  typedef logic [SERIALIZE_MAX_LANES-1:0] lane_mask_t;

  function automatic int lane_idx_width(input int lanes);
    return (lanes > 1) ? $clog2(lanes) : 1;
  endfunction

endpackage

// File: rtl/rename_serialize_ctrl_if.sv
// Rename-group bus between the rename pipeline (master) and the serializer (slave).
interface rename_serialize_ctrl_if #(
  parameter int WIDTH     = 2,
  parameter int CNT_WIDTH = 16
);
  logic                 extStall;
  logic                 clear;
  logic                 activeListEmpty;
  logic                 storeQueueEmpty;
  logic [WIDTH-1:0]     valid;
  logic [WIDTH-1:0]     serialized;
  logic [WIDTH-1:0]     needSqDrain;
  logic [WIDTH-1:0]     waitOwn;
  logic [WIDTH-1:0]     passMask;
  logic                 serialize;
  logic                 busy;
  logic [CNT_WIDTH-1:0] serializeCycles;

  modport master (
    output extStall, clear, activeListEmpty, storeQueueEmpty,
           valid, serialized, needSqDrain, waitOwn,
    input  passMask, serialize, busy, serializeCycles
  );

  modport slave (
    input  extStall, clear, activeListEmpty, storeQueueEmpty,
           valid, serialized, needSqDrain, waitOwn,
    output passMask, serialize, busy, serializeCycles
  );
endinterface

// File: rtl/rename_serialize_ctrl_lane_sel.sv
// Lowest-set-bit encoder: index of the first requesting lane, a found flag and
// the mask of lanes strictly below it.
module SerializeLaneSelector
  import RenameSerializerTypes::*;
#(
  parameter int WIDTH = 2,
  parameter int IDX_W = lane_idx_width(WIDTH)
) (
  input  logic [WIDTH-1:0] req,
  output logic [IDX_W-1:0] k_idx,
  output logic             k_valid,
  output logic [WIDTH-1:0] below_mask
);

  logic found;

  // NOTE: every combinational output gets a default before the loop, so no
  // path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    found      = 1'b0;
    k_idx      = '0;
    below_mask = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (!found && req[i]) begin
        found = 1'b1;
        k_idx = IDX_W'(i);
      end else if (!found) begin
        below_mask[i] = 1'b1;
      end
    end
    k_valid = found;
  end

endmodule

// File: rtl/rename_serialize_ctrl.sv
// Serializes rename groups: lanes ahead of a serializing op pass first, the op
// waits for the machine to drain, then younger lanes follow in lane order.
module rename_serialize_ctrl
  import RenameSerializerTypes::*;
#(
  parameter int WIDTH     = 2,
  parameter int CNT_WIDTH = SERIALIZE_CNT_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst,
  rename_serialize_ctrl_if.slave  bus
);

  localparam int               IDX_W    = lane_idx_width(WIDTH);
  localparam logic [WIDTH-1:0] LANE_ONE = WIDTH'(1);

  SerializePhase        phase_q, phase_d;
  logic [WIDTH-1:0]     done_q, done_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

  logic [WIDTH-1:0] eff_valid, sel_req, below_mask, k_onehot;
  logic [IDX_W-1:0] k_idx;
  logic             k_valid, lower_live, above_live, need_sq, own, drain_ok;
  logic [WIDTH-1:0] pass_mask;
  logic             serialize_o, busy_o;

  assign eff_valid = bus.valid & ~done_q;
  assign sel_req   = eff_valid & bus.serialized;

  SerializeLaneSelector #(.WIDTH(WIDTH), .IDX_W(IDX_W)) u_sel (
    .req        (sel_req),
    .k_idx      (k_idx),
    .k_valid    (k_valid),
    .below_mask (below_mask)
  );

  assign k_onehot   = k_valid ? (LANE_ONE << k_idx) : '0;
  assign lower_live = |(eff_valid & below_mask);
  assign above_live = |(eff_valid & ~below_mask & ~k_onehot);
  assign need_sq    = bus.needSqDrain[k_idx];
  assign own        = bus.waitOwn[k_idx];
  assign drain_ok   = bus.activeListEmpty && (bus.storeQueueEmpty || !need_sq);

  // NOTE: state flops use non-blocking assignments so every flop samples the
  // pre-edge values; reset is asynchronous and returns straight to SP_NORMAL.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      phase_q <= SP_NORMAL;
      done_q  <= '0;
      cnt_q   <= '0;
    end else begin
      phase_q <= phase_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    phase_d = phase_q;
    done_d  = done_q;
    if (bus.clear) begin
      phase_d = SP_NORMAL;
      done_d  = '0;
    end else if (!bus.extStall) begin
      unique case (phase_q)
        SP_NORMAL:   if (k_valid && !lower_live) phase_d = SP_DRAIN;
        SP_DRAIN: begin
          if (!k_valid)      phase_d = SP_NORMAL;
          else if (drain_ok) phase_d = own ? SP_WAIT_OWN : SP_NORMAL;
        end
        SP_WAIT_OWN: if (bus.activeListEmpty && bus.storeQueueEmpty) phase_d = SP_NORMAL;
        default:     phase_d = SP_NORMAL;
      endcase
      // Once serialize drops the upstream group advances, so the done set resets.
      done_d = serialize_o ? (done_q | pass_mask) : '0;
    end
  end

  // The counter keeps running through external stalls; it measures hold time.
  always_comb begin
    cnt_d = cnt_q;
    if (serialize_o && (cnt_q != '1)) cnt_d = cnt_q + CNT_WIDTH'(1);
  end

  always_comb begin
    pass_mask   = '0;
    serialize_o = 1'b0;
    if (!bus.clear) begin
      unique case (phase_q)
        SP_NORMAL: begin
          if (!k_valid) begin
            pass_mask = eff_valid;
          end else begin
            pass_mask   = lower_live ? (eff_valid & below_mask) : '0;
            serialize_o = 1'b1;
          end
        end
        SP_DRAIN: begin
          // A group that lost its serializing lane has nothing left to hold.
          if (k_valid) begin
            serialize_o = 1'b1;
            if (drain_ok) begin
              pass_mask   = k_onehot;
              serialize_o = above_live || own;
            end
          end
        end
        SP_WAIT_OWN: serialize_o = 1'b1;
        default: begin
          pass_mask   = '0;
          serialize_o = 1'b0;
        end
      endcase
    end
  end

  assign busy_o = (phase_q != SP_NORMAL) || (|done_q);

  assign bus.passMask        = pass_mask;
  assign bus.serialize       = serialize_o;
  assign bus.busy            = busy_o;
  assign bus.serializeCycles = cnt_q;

endmodule

// File: tb/tb_rename_serialize_ctrl.sv
// Directed bench: a 2-lane instance with a 4-bit counter and a 4-lane instance,
// driven from vector tables and short hand-written multi-cycle sequences.
module tb_rename_serialize_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  rename_serialize_ctrl_if #(.WIDTH(2), .CNT_WIDTH(4))  ifa ();
  rename_serialize_ctrl_if #(.WIDTH(4), .CNT_WIDTH(16)) ifb ();

  rename_serialize_ctrl #(.WIDTH(2), .CNT_WIDTH(4)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (ifa)
  );

  rename_serialize_ctrl #(.WIDTH(4), .CNT_WIDTH(16)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (ifb)
  );

  typedef struct {
    logic [3:0] v;
    logic [3:0] s;
    logic [3:0] nsq;
    logic [3:0] wo;
    logic [3:0] pass;
    logic       ser;
  } vec_t;

  vec_t vecs [10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive one cycle on the 2-lane instance, check mid-cycle, then clock it.
  task automatic a_cycle(input string tag, input logic stall, input logic clr,
                         input logic ale, input logic sqe,
                         input logic [1:0] v, input logic [1:0] s,
                         input logic [1:0] nsq, input logic [1:0] wo,
                         input logic [1:0] exp_pass, input logic exp_ser,
                         input logic exp_busy);
    ifa.extStall        = stall;
    ifa.clear           = clr;
    ifa.activeListEmpty = ale;
    ifa.storeQueueEmpty = sqe;
    ifa.valid           = v;
    ifa.serialized      = s;
    ifa.needSqDrain     = nsq;
    ifa.waitOwn         = wo;
    #3;
    check({tag, ".pass"}, 32'(ifa.passMask), 32'(exp_pass));
    check({tag, ".ser"},  32'(ifa.serialize), 32'(exp_ser));
    check({tag, ".busy"}, 32'(ifa.busy), 32'(exp_busy));
    @(posedge clk);
    #1;
  endtask

  task automatic b_cycle(input string tag, input logic stall,
                         input logic [3:0] v, input logic [3:0] s,
                         input logic [3:0] exp_pass, input logic exp_ser,
                         input logic exp_busy);
    ifb.extStall        = stall;
    ifb.clear           = 1'b0;
    ifb.activeListEmpty = 1'b1;
    ifb.storeQueueEmpty = 1'b1;
    ifb.valid           = v;
    ifb.serialized      = s;
    ifb.needSqDrain     = 4'b0000;
    ifb.waitOwn         = 4'b0000;
    #3;
    check({tag, ".pass"}, 32'(ifb.passMask), 32'(exp_pass));
    check({tag, ".ser"},  32'(ifb.serialize), 32'(exp_ser));
    check({tag, ".busy"}, 32'(ifb.busy), 32'(exp_busy));
    @(posedge clk);
    #1;
  endtask

  initial begin
    ifa.extStall = 1'b0; ifa.clear = 1'b0; ifa.activeListEmpty = 1'b0; ifa.storeQueueEmpty = 1'b0;
    ifa.valid = '0; ifa.serialized = '0; ifa.needSqDrain = '0; ifa.waitOwn = '0;
    ifb.extStall = 1'b0; ifb.clear = 1'b0; ifb.activeListEmpty = 1'b0; ifb.storeQueueEmpty = 1'b0;
    ifb.valid = '0; ifb.serialized = '0; ifb.needSqDrain = '0; ifb.waitOwn = '0;

    //            v        s        nsq      wo       pass     ser
    vecs[0] = '{4'b0000, 4'b1111, 4'b1111, 4'b1111, 4'b0000, 1'b0};
    vecs[1] = '{4'b1111, 4'b0000, 4'b0000, 4'b0000, 4'b1111, 1'b0};
    vecs[2] = '{4'b1010, 4'b0000, 4'b1111, 4'b1111, 4'b1010, 1'b0};
    vecs[3] = '{4'b1111, 4'b0100, 4'b0000, 4'b0000, 4'b0011, 1'b1};
    vecs[4] = '{4'b1110, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 1'b1};
    vecs[5] = '{4'b0101, 4'b1010, 4'b1010, 4'b1010, 4'b0101, 1'b0};
    vecs[6] = '{4'b1111, 4'b1000, 4'b0000, 4'b0000, 4'b0111, 1'b1};
    vecs[7] = '{4'b1111, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 1'b1};
    vecs[8] = '{4'b1100, 4'b1100, 4'b1111, 4'b1111, 4'b0000, 1'b1};
    vecs[9] = '{4'b1011, 4'b1010, 4'b0000, 4'b0000, 4'b0001, 1'b1};

    // Reset state
    #2;
    check("rst.a.pass", 32'(ifa.passMask), 32'd0);
    check("rst.a.ser",  32'(ifa.serialize), 32'd0);
    check("rst.a.busy", 32'(ifa.busy), 32'd0);
    check("rst.a.cnt",  32'(ifa.serializeCycles), 32'd0);
    check("rst.b.busy", 32'(ifb.busy), 32'd0);
    check("rst.b.cnt",  32'(ifb.serializeCycles), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;

    // Single-cycle decode from the idle state; extStall keeps the state frozen
    ifb.extStall = 1'b1;
    ifb.activeListEmpty = 1'b1;
    ifb.storeQueueEmpty = 1'b1;
    for (int i = 0; i < 10; i++) begin
      ifb.valid       = vecs[i].v;
      ifb.serialized  = vecs[i].s;
      ifb.needSqDrain = vecs[i].nsq;
      ifb.waitOwn     = vecs[i].wo;
      #3;
      check($sformatf("vec%0d.pass", i), 32'(ifb.passMask), 32'(vecs[i].pass));
      check($sformatf("vec%0d.ser", i),  32'(ifb.serialize), 32'(vecs[i].ser));
      check($sformatf("vec%0d.busy", i), 32'(ifb.busy), 32'd0);
      @(posedge clk);
      #1;
    end

    // Four lanes, serialized on lanes 1 and 3, with one stalled drain cycle
    b_cycle("w4.c0", 1'b0, 4'b1111, 4'b1010, 4'b0001, 1'b1, 1'b0);
    b_cycle("w4.c1", 1'b0, 4'b1111, 4'b1010, 4'b0000, 1'b1, 1'b1);
    b_cycle("w4.c2", 1'b1, 4'b1111, 4'b1010, 4'b0010, 1'b1, 1'b1);
    b_cycle("w4.c3", 1'b0, 4'b1111, 4'b1010, 4'b0010, 1'b1, 1'b1);
    b_cycle("w4.c4", 1'b0, 4'b1111, 4'b1010, 4'b0100, 1'b1, 1'b1);
    b_cycle("w4.c5", 1'b0, 4'b1111, 4'b1010, 4'b0000, 1'b1, 1'b1);
    b_cycle("w4.c6", 1'b0, 4'b1111, 4'b1010, 4'b1000, 1'b0, 1'b1);
    b_cycle("w4.c7", 1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0);

    // Plain lane0 ahead of serialized lane1, waiting on the active list
    //       tag       stl   clr   ale   sqe   v      s      nsq    wo     pass   ser   busy
    a_cycle("ser.c0", 1'b0, 1'b0, 1'b0, 1'b1, 2'b11, 2'b10, 2'b00, 2'b00, 2'b01, 1'b1, 1'b0);
    a_cycle("ser.c1", 1'b0, 1'b0, 1'b0, 1'b1, 2'b11, 2'b10, 2'b00, 2'b00, 2'b00, 1'b1, 1'b1);
    a_cycle("ser.c2", 1'b0, 1'b0, 1'b0, 1'b1, 2'b11, 2'b10, 2'b00, 2'b00, 2'b00, 1'b1, 1'b1);
    a_cycle("ser.c3", 1'b0, 1'b0, 1'b1, 1'b1, 2'b11, 2'b10, 2'b00, 2'b00, 2'b10, 1'b0, 1'b1);
    a_cycle("ser.c4", 1'b0, 1'b0, 1'b1, 1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0);

    // Fence on lane0: store-queue drain, then wait for its own commit
    a_cycle("fen.c0", 1'b0, 1'b0, 1'b1, 1'b0, 2'b01, 2'b01, 2'b01, 2'b01, 2'b00, 1'b1, 1'b0);
    a_cycle("fen.c1", 1'b0, 1'b0, 1'b1, 1'b0, 2'b01, 2'b01, 2'b01, 2'b01, 2'b00, 1'b1, 1'b1);
    a_cycle("fen.c2", 1'b0, 1'b0, 1'b1, 1'b0, 2'b01, 2'b01, 2'b01, 2'b01, 2'b00, 1'b1, 1'b1);
    a_cycle("fen.c3", 1'b0, 1'b0, 1'b1, 1'b0, 2'b01, 2'b01, 2'b01, 2'b01, 2'b00, 1'b1, 1'b1);
    a_cycle("fen.c4", 1'b0, 1'b0, 1'b1, 1'b1, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 1'b1, 1'b1);
    a_cycle("fen.c5", 1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 2'b01, 2'b01, 2'b01, 2'b00, 1'b1, 1'b1);
    a_cycle("fen.c6", 1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 2'b01, 2'b01, 2'b01, 2'b00, 1'b1, 1'b1);
    a_cycle("fen.c7", 1'b0, 1'b0, 1'b1, 1'b1, 2'b01, 2'b01, 2'b01, 2'b01, 2'b00, 1'b1, 1'b1);
    a_cycle("fen.c8", 1'b0, 1'b0, 1'b1, 1'b1, 2'b01, 2'b01, 2'b01, 2'b01, 2'b00, 1'b0, 1'b1);
    a_cycle("fen.c9", 1'b0, 1'b0, 1'b1, 1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0);

    // Flush while waiting on own commit, with an external stall also asserted
    a_cycle("clr.c0", 1'b0, 1'b0, 1'b1, 1'b1, 2'b01, 2'b01, 2'b00, 2'b01, 2'b00, 1'b1, 1'b0);
    a_cycle("clr.c1", 1'b0, 1'b0, 1'b1, 1'b1, 2'b01, 2'b01, 2'b00, 2'b01, 2'b01, 1'b1, 1'b1);
    a_cycle("clr.c2", 1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 2'b01, 2'b00, 2'b01, 2'b00, 1'b1, 1'b1);
    a_cycle("clr.c3", 1'b1, 1'b1, 1'b0, 1'b1, 2'b01, 2'b01, 2'b00, 2'b01, 2'b00, 1'b0, 1'b1);
    a_cycle("clr.c4", 1'b1, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0);

    // Counter saturation on the 4-bit instance, then asynchronous reset mid-drain
    ifa.extStall = 1'b0;
    ifa.valid    = 2'b00;
    rst = 1'b0;
    #1;
    check("cnt.rst0", 32'(ifa.serializeCycles), 32'd0);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 20; i++) begin
      a_cycle($sformatf("cnt.c%0d", i), (i % 2 == 1), 1'b0, 1'b0, 1'b0,
              2'b01, 2'b01, 2'b01, 2'b00, 2'b00, 1'b1, (i != 0));
      if (i == 4 || i == 14 || i == 15 || i == 19)
        check($sformatf("cnt.after%0d", i + 1), 32'(ifa.serializeCycles),
              32'((i + 1 > 15) ? 15 : i + 1));
    end
    #2;
    ifa.valid = 2'b00;
    rst = 1'b0;
    #1;
    check("arst.cnt",  32'(ifa.serializeCycles), 32'd0);
    check("arst.busy", 32'(ifa.busy), 32'd0);
    check("arst.pass", 32'(ifa.passMask), 32'd0);
    check("arst.ser",  32'(ifa.serialize), 32'd0);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("post.cnt", 32'(ifa.serializeCycles), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
